// File: rtl/trdb_packet_arbiter_if.sv
// Handshake bundle between the packet producers, the arbiter and the packet readout.
// The arbiter connects through the slave modport; producers/readout through master.
interface trdb_packet_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PKT_W   = 128,
    parameter int unsigned LEN_W   = 7,
    parameter int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*PKT_W-1:0] req_data_i;
    logic [NUM_REQ*LEN_W-1:0] req_len_i;

    logic                     pkt_valid_o;
    logic                     pkt_ready_i;
    logic [PKT_W-1:0]         pkt_data_o;
    logic [LEN_W-1:0]         pkt_len_o;
    logic [SRC_W-1:0]         pkt_src_o;

    modport master (
        output req_valid_i,
        output req_data_i,
        output req_len_i,
        input  req_ready_o,
        input  pkt_valid_o,
        output pkt_ready_i,
        input  pkt_data_o,
        input  pkt_len_o,
        input  pkt_src_o
    );

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  req_len_i,
        output req_ready_o,
        output pkt_valid_o,
        input  pkt_ready_i,
        output pkt_data_o,
        output pkt_len_o,
        output pkt_src_o
    );
endinterface

// File: rtl/trdb_packet_arbiter.sv
// Trace debugger packet arbiter: strict-priority sync requester plus round robin over
// the others, one-entry registered valid/ready output, and a flush/drain sequencer.
module trdb_packet_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PKT_W    = 128,
    parameter int unsigned LEN_W    = 7,
    parameter int unsigned SYNC_IDX = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    trdb_packet_arbiter_if.slave  bus,
    input  logic                  flush_i,
    output logic                  flush_done_o
);

    localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic               arb_en;

    logic [SRC_W-1:0]   rr_ptr_q;
    logic [SRC_W-1:0]   win_idx;
    logic               win_found;
    int unsigned        scan_idx;
    logic [PKT_W-1:0]   win_data;
    logic [LEN_W-1:0]   win_len;

    logic               slot_free;
    logic               grant;
    logic               accept;

    // Sync requester preempts; otherwise scan from rr_ptr with wrap, never landing on SYNC_IDX.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        if (bus.req_valid_i[SYNC_IDX]) begin
            win_idx   = SRC_W'(SYNC_IDX);
            win_found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= NUM_REQ) begin
                    scan_idx = scan_idx - NUM_REQ;
                end
                if (!win_found && scan_idx != SYNC_IDX && bus.req_valid_i[scan_idx]) begin
                    win_idx   = SRC_W'(scan_idx);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_data = bus.req_data_i[int'(win_idx)*PKT_W +: PKT_W];
        win_len  = bus.req_len_i[int'(win_idx)*LEN_W +: LEN_W];
    end

    assign slot_free = !bus.pkt_valid_o || bus.pkt_ready_i;

    // Gated by reset so no requester sees an accept while the block is held in reset.
    assign grant  = rst_ni && arb_en && slot_free && win_found;
    assign accept = grant && (win_len != '0);

    always_comb begin
        bus.req_ready_o = '0;
        if (grant) begin
            bus.req_ready_o[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.pkt_valid_o <= 1'b0;
            bus.pkt_data_o  <= '0;
            bus.pkt_len_o   <= '0;
            bus.pkt_src_o   <= '0;
        end else if (accept) begin
            bus.pkt_valid_o <= 1'b1;
            bus.pkt_data_o  <= win_data;
            bus.pkt_len_o   <= win_len;
            bus.pkt_src_o   <= win_idx;
        end else if (bus.pkt_ready_i) begin
            bus.pkt_valid_o <= 1'b0;
        end
    end

    // Zero-length grants still advance the pointer; sync grants never do.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (grant && win_idx != SRC_W'(SYNC_IDX)) begin
            if (win_idx == SRC_W'(NUM_REQ - 1)) begin
                rr_ptr_q <= '0;
            end else begin
                rr_ptr_q <= win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing left upstream and the output slot empties this cycle.
                if (!win_found && (!bus.pkt_valid_o || bus.pkt_ready_i)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        arb_en       = (state_q != DONE);
        flush_done_o = (state_q == DONE);
    end

endmodule
